// File: rtl/id_inst_buffer_pkg.sv
// Shared widths and defaults for the fetch-to-decode instruction buffer.
package id_inst_buffer_pkg;

    localparam int BUS_64       = 64;
    localparam int BUS_32       = 32;
    localparam int ID_BUF_DEPTH = 4;

    // Storage word layout: {fault, pc_pred, pc, inst}
    function automatic int id_buf_word_w(input int pc_w, input int inst_w);
        return 2 * pc_w + inst_w + 1;
    endfunction

endpackage

// File: rtl/id_buf_mem.sv
// Register array: one synchronous write port, one asynchronous read port.
// Every word clears to zero on reset so the head outputs read zero afterwards.
module id_buf_mem
    import id_inst_buffer_pkg::*;
#(
    parameter int DEPTH = ID_BUF_DEPTH,
    parameter int WIDTH = id_buf_word_w(BUS_64, BUS_32),
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write the pushed bundle; clear every entry on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Head is read straight out of storage, no output register.
    always_comb begin
        o_rdata = r_mem[i_raddr];
    end

endmodule

// File: rtl/id_inst_buffer.sv
// Instruction buffer between fetch and decode. Holds up to DEPTH bundles in
// FIFO order, back-pressures fetch when full, and discards everything on flush.
//
// Handshake: both sides use req/ack. A transfer happens on a rising edge where
// req and ack are both high. req is the producer's claim that the data is valid
// and must hold its data while high; ack is the consumer's willingness for this
// cycle. Fetch side: push = i_fetched_req & o_fetched_ack. Decode side:
// pop = o_decoded_req & i_decoded_ack.
//
// With FULL_PASS=1, o_fetched_ack depends combinationally on i_decoded_ack
// (a full buffer accepts a push in the cycle decode pops). The integrating
// pipeline must not make i_decoded_ack depend on o_fetched_ack, or a
// combinational loop results.
module id_inst_buffer
    import id_inst_buffer_pkg::*;
#(
    parameter int DEPTH     = ID_BUF_DEPTH,
    parameter int PC_W      = BUS_64,
    parameter int INST_W    = BUS_32,
    parameter int FULL_PASS = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_fetched_req,
    output logic                       o_fetched_ack,
    input  logic [PC_W-1:0]            i_pc,
    input  logic [INST_W-1:0]          i_inst,
    input  logic [PC_W-1:0]            i_pc_pred,
    input  logic                       i_fault,
    output logic                       o_decoded_req,
    input  logic                       i_decoded_ack,
    output logic [PC_W-1:0]            o_pc,
    output logic [INST_W-1:0]          o_inst,
    output logic [PC_W-1:0]            o_pc_pred,
    output logic                       o_fault,
    input  logic                       i_flush,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int   PTR_W   = $clog2(DEPTH);
    localparam int   CNT_W   = $clog2(DEPTH + 1);
    localparam int   WORD_W  = id_buf_word_w(PC_W, INST_W);
    localparam logic LP_PASS = (FULL_PASS != 0);

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_push;
    logic              w_pop;
    logic [WORD_W-1:0] w_wdata;
    logic [WORD_W-1:0] w_rdata;

    // Status flags and handshake outputs derived from occupancy.
    always_comb begin
        o_count       = r_count;
        o_full        = (r_count == CNT_W'(DEPTH));
        o_empty       = (r_count == '0);
        o_decoded_req = !o_empty;
        o_fetched_ack = rst & !i_flush & (!o_full | (LP_PASS & i_decoded_ack));
        w_push        = i_fetched_req & o_fetched_ack;
        w_pop         = o_decoded_req & i_decoded_ack;
        w_wdata       = {i_fault, i_pc_pred, i_pc, i_inst};
    end

    // Unpack the head word into the payload outputs.
    always_comb begin
        o_inst    = w_rdata[INST_W-1:0];
        o_pc      = w_rdata[INST_W +: PC_W];
        o_pc_pred = w_rdata[INST_W+PC_W +: PC_W];
        o_fault   = w_rdata[WORD_W-1];
    end

    // Pointers and occupancy; flush overrides any push or pop in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    id_buf_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W),
        .AW    (PTR_W)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wdata),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

endmodule
